aes_round_ctrl: RTL and testbench

- Control FSM for the iterative AES-128 encrypt datapath.
- Accepts a block through a valid/ready handshake and drives the round counter's enable. Consumes the counter's completion flag.
- Generates per-round datapath strobes: initial AddRoundKey, full round, final round without MixColumns.
- Presents the result through a valid/ready output handshake.
- Sits between the top-level I/O wrapper and the round datapath/key-schedule; it is the sole driver of round_count_en.

---
 rtl/aes_pkg.sv | 14 +
 rtl/aes_round_ctrl_if.sv | 23 ++
 rtl/aes_strobe_dec.sv | 26 ++
 rtl/aes_round_ctrl.sv | 88 ++++++++
 tb/tb_aes_round_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared types and constants for the iterative AES-128 round controller.
package aes_pkg;

  localparam int unsigned AES_NUM_ROUNDS = 10;
  localparam int unsigned AES_CNT_W      = 4;
  localparam int unsigned AES_LAST_CNT   = AES_NUM_ROUNDS + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } aes_ctrl_state_e;

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Block-in / ciphertext-out valid/ready handshake bundle for aes_round_ctrl.
interface aes_round_ctrl_if;

  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;

  modport master (
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out_valid
  );

endinterface

// File: rtl/aes_strobe_dec.sv
// Combinational decode of controller state and round index into datapath strobes.
module aes_strobe_dec
  import aes_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = AES_NUM_ROUNDS,
  parameter int unsigned CNT_W      = AES_CNT_W
) (
  input  aes_ctrl_state_e  state,
  input  logic [CNT_W-1:0] round_idx,
  output logic             state_we,
  output logic             sel_init,
  output logic             skip_mix
);

  localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(NUM_ROUNDS);

  logic run;
  assign run = (state == RUN);

  always_comb begin
    state_we = run && (round_idx <= LAST_RND);
    sel_init = run && (round_idx == '0);
    skip_mix = run && (round_idx == LAST_RND);
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// Control FSM for the iterative AES-128 encrypt datapath.
// Optional completion-consistency checker enabled by defining AES_CTRL_CHK_EN.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = AES_NUM_ROUNDS,
  parameter int unsigned CNT_W      = AES_CNT_W
) (
  input  logic             clk,
  input  logic             n_rst,
  aes_round_ctrl_if.slave  hs,
  input  logic             is_round_completed,
  output logic             round_count_en,
  output logic [CNT_W-1:0] round_idx,
  output logic             state_we,
  output logic             sel_init,
  output logic             skip_mix,
  output logic             busy
`ifdef AES_CTRL_CHK_EN
  ,
  output logic             chk_err
`endif
);

  aes_ctrl_state_e state;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (hs.in_valid)         state <= RUN;
        RUN:     if (is_round_completed)  state <= DONE;
        DONE:    if (hs.out_ready)        state <= IDLE;
        default:                          state <= IDLE;
      endcase
    end
  end

  // Enable is decoded from the reset-cleared state so it falls with n_rst, clearing the counter.
  assign round_count_en = (state == RUN) && !is_round_completed;

  // round_idx shadows the external counter: same increment/clear rule, same reset value.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      round_idx <= '0;
    end else if (round_count_en) begin
      round_idx <= round_idx + CNT_W'(1);
    end else begin
      round_idx <= '0;
    end
  end

  assign hs.in_ready  = (state == IDLE);
  assign hs.out_valid = (state == DONE);
  assign busy         = (state != IDLE);

  aes_strobe_dec #(
    .NUM_ROUNDS (NUM_ROUNDS),
    .CNT_W      (CNT_W)
  ) u_strobe_dec (
    .state     (state),
    .round_idx (round_idx),
    .state_we  (state_we),
    .sel_init  (sel_init),
    .skip_mix  (skip_mix)
  );

`ifdef AES_CTRL_CHK_EN
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_ROUNDS + 1);

  logic cmp_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cmp_q   <= 1'b0;
      chk_err <= 1'b0;
    end else begin
      cmp_q <= is_round_completed;
      if (((state == RUN) && is_round_completed && !cmp_q && (round_idx != LAST_IDX)) ||
          ((round_idx == LAST_IDX) && !is_round_completed)) begin
        chk_err <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl with a behavioural round counter in the loop.
module tb_aes_round_ctrl;
  import aes_pkg::*;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       force_cmp = 1'b0;
  logic       is_round_completed;
  logic       round_count_en;
  logic [3:0] round_idx;
  logic       state_we, sel_init, skip_mix, busy;
  logic [3:0] cnt = '0;
`ifdef AES_CTRL_CHK_EN
  logic       chk_err;
`endif

  int n_cmp = 0;
  int n_err = 0;

  aes_round_ctrl_if hs ();

  aes_round_ctrl #(
    .NUM_ROUNDS (10),
    .CNT_W      (4)
  ) dut (
    .clk                (clk),
    .n_rst              (n_rst),
    .hs                 (hs),
    .is_round_completed (is_round_completed),
    .round_count_en     (round_count_en),
    .round_idx          (round_idx),
    .state_we           (state_we),
    .sel_init           (sel_init),
    .skip_mix           (skip_mix),
    .busy               (busy)
`ifdef AES_CTRL_CHK_EN
    ,
    .chk_err            (chk_err)
`endif
  );

  always #5 clk = ~clk;

  // External round counter: counts while enabled, clears otherwise; no reset of its own.
  always @(posedge clk) cnt <= round_count_en ? cnt + 4'd1 : 4'd0;
  assign is_round_completed = (cnt == 4'd11) || force_cmp;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chkn(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk1({tag, " in_ready"},  hs.in_ready,     1'b1);
    chk1({tag, " out_valid"}, hs.out_valid,    1'b0);
    chk1({tag, " busy"},      busy,            1'b0);
    chk1({tag, " en"},        round_count_en,  1'b0);
    chk4({tag, " idx"},       round_idx,       4'd0);
    chk1({tag, " state_we"},  state_we,        1'b0);
    chk1({tag, " sel_init"},  sel_init,        1'b0);
    chk1({tag, " skip_mix"},  skip_mix,        1'b0);
  endtask

  typedef struct {
    logic       in_valid;
    logic       out_ready;
    logic       force_cmp;
    logic       in_ready;
    logic       out_valid;
    logic       busy;
    logic       en;
    logic [3:0] idx;
    logic       we;
    logic       sel;
    logic       skip;
  } vec_t;

  vec_t vec[16];

  function automatic vec_t mk(input logic iv, input logic orr, input logic fc,
                              input logic ir, input logic ov, input logic bz,
                              input logic en, input logic [3:0] idx,
                              input logic we, input logic sel, input logic skip);
    vec_t v;
    v.in_valid = iv; v.out_ready = orr; v.force_cmp = fc;
    v.in_ready = ir; v.out_valid = ov; v.busy = bz; v.en = en;
    v.idx = idx; v.we = we; v.sel = sel; v.skip = skip;
    return v;
  endfunction

  initial begin
    int m;

    // Single block, out_ready=1. Row 0 is accept cycle T (with a stray completion pulse
    // in IDLE), rows 1..11 are rounds 0..10, row 12 completion, row 13 DONE, rows 14/15 IDLE.
    vec[0]  = mk(1, 1, 1,  1, 0, 0, 0, 4'd0,  0, 0, 0);
    vec[1]  = mk(0, 1, 0,  0, 0, 1, 1, 4'd0,  1, 1, 0);
    for (int unsigned k = 2; k <= 10; k++)
      vec[k] = mk(0, 1, 0, 0, 0, 1, 1, 4'(k - 1), 1, 0, 0);
    vec[5].in_valid = 1'b1;
    vec[11] = mk(0, 1, 0,  0, 0, 1, 1, 4'd10, 1, 0, 1);
    vec[12] = mk(0, 1, 0,  0, 0, 1, 0, 4'd11, 0, 0, 0);
    vec[13] = mk(0, 1, 1,  0, 1, 1, 0, 4'd0,  0, 0, 0);
    vec[14] = mk(0, 1, 1,  1, 0, 0, 0, 4'd0,  0, 0, 0);
    vec[15] = mk(0, 1, 0,  1, 0, 0, 0, 4'd0,  0, 0, 0);

    hs.in_valid  = 1'b0;
    hs.out_ready = 1'b0;
    #1;
    chk_idle("reset");
    repeat (2) step();
    n_rst = 1'b1;
    step();
    chk_idle("post-reset");

    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      hs.in_valid  = vec[k].in_valid;
      hs.out_ready = vec[k].out_ready;
      force_cmp    = vec[k].force_cmp;
      #1;
      chk1($sformatf("row%0d in_ready", k),  hs.in_ready,    vec[k].in_ready);
      chk1($sformatf("row%0d out_valid", k), hs.out_valid,   vec[k].out_valid);
      chk1($sformatf("row%0d busy", k),      busy,           vec[k].busy);
      chk1($sformatf("row%0d en", k),        round_count_en, vec[k].en);
      chk4($sformatf("row%0d idx", k),       round_idx,      vec[k].idx);
      chk4($sformatf("row%0d idx_vs_cnt", k), round_idx,     cnt);
      chk1($sformatf("row%0d state_we", k),  state_we,       vec[k].we);
      chk1($sformatf("row%0d sel_init", k),  sel_init,       vec[k].sel);
      chk1($sformatf("row%0d skip_mix", k),  skip_mix,       vec[k].skip);
    end
    force_cmp = 1'b0;

    // Backpressure: out_ready low for 5 DONE cycles while a new block is offered.
    hs.in_valid  = 1'b1;
    hs.out_ready = 1'b0;
    chk1("bp accept in_ready", hs.in_ready, 1'b1);
    repeat (13) step();
    for (int i = 0; i < 5; i++) begin
      chk1($sformatf("bp%0d out_valid", i), hs.out_valid, 1'b1);
      chk1($sformatf("bp%0d in_ready", i),  hs.in_ready,  1'b0);
      chk1($sformatf("bp%0d en", i),        round_count_en, 1'b0);
      step();
    end
    chk1("bp release out_valid", hs.out_valid, 1'b1);
    hs.out_ready = 1'b1;
    step();
    chk1("bp idle in_ready",  hs.in_ready,  1'b1);
    chk1("bp idle out_valid", hs.out_valid, 1'b0);
    step();
    chk1("bb1 busy",     busy,      1'b1);
    chk4("bb1 idx",      round_idx, 4'd0);
    chk4("bb1 cnt",      cnt,       4'd0);
    chk1("bb1 sel_init", sel_init,  1'b1);

    // Back-to-back: in_valid held, out_ready=1.
    repeat (12) step();
    chk1("bb1 out_valid", hs.out_valid, 1'b1);
    step();
    chk1("bb2 out_valid drop", hs.out_valid, 1'b0);
    chk1("bb2 in_ready",       hs.in_ready,  1'b1);
    step();
    chk1("bb2 busy", busy,      1'b1);
    chk4("bb2 idx",  round_idx, 4'd0);
    chk4("bb2 cnt",  cnt,       4'd0);
    hs.in_valid = 1'b0;

    // Reset in the middle of round 6.
    repeat (6) step();
    chk4("mid idx", round_idx, 4'd6);
    chk4("mid cnt", cnt,       4'd6);
    #2 n_rst = 1'b0;
    #1;
    chk_idle("async reset");
    step();
    n_rst = 1'b1;
    #1;
    chk4("post-reset cnt", cnt, 4'd0);
    chk_idle("post-reset2");

    hs.in_valid  = 1'b1;
    hs.out_ready = 1'b1;
    step();
    hs.in_valid = 1'b0;
    m = 1;
    while (!hs.out_valid && m < 30) begin
      step();
      m++;
    end
    chkn("latency to out_valid", m, 13);
    step();
    chk_idle("latency idle");

`ifdef AES_CTRL_CHK_EN
    chk1("chk_err clean", chk_err, 1'b0);
    hs.in_valid = 1'b1;
    step();
    hs.in_valid = 1'b0;
    repeat (5) step();
    chk4("chk idx5", round_idx, 4'd5);
    force_cmp = 1'b1;
    step();
    force_cmp = 1'b0;
    chk1("chk_err set", chk_err, 1'b1);
    repeat (3) step();
    chk1("chk_err sticky", chk_err, 1'b1);
    n_rst = 1'b0;
    #1;
    chk1("chk_err reset", chk_err, 1'b0);
    step();
    n_rst = 1'b1;
`endif

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
